alu_exec_seq: RTL
=================

// Module: alu_exec_seq
// PURPOSE
//  Execution-stage ALU that consumes the 3-bit operation code (gout) produced by the
//  ALU control decoder. It performs the selected operation on two operands and returns
//  a registered result and zero flag over a valid/ready handshake.
//  Logical and arithmetic ops take one cycle. SLL is iterative, one bit per cycle.
//  Sits between the register-file read stage and the writeback/branch-compare logic.
// PARAMETERS
//  WIDTH   32   operand/result width in bits
//  SHW     5    shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk        in   1      system clock; all state updates on rising edge
//  reset_n    in   1      synchronous, active-low reset
//  in_valid   in   1      upstream presents gout/a/b/shamt
//  in_ready   out  1      block can accept an operation
//  gout       in   3      operation code from ALU control
//  a          in   WIDTH  operand A (rs)
//  b          in   WIDTH  operand B (rt / immediate); shift source for SLL
//  shamt      in   SHW    shift amount, used only when gout=100
//  out_valid  out  1      result/zero/err valid
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  operation result
//  zero       out  1      1 when result==0
//  err        out  1      1 when the accepted gout was illegal
// BEHAVIOUR
//  Opcodes:
//   000 AND   001 OR    010 ADD   110 SUB   111 SLT (signed)
//   011 NOR   100 SLL b<<shamt    101 illegal
//  ADD/SUB wrap modulo 2^WIDTH. No overflow trap.
//  SLT result = {0..0, (a-b)[MSB] ^ ovf}, which is correct across signed overflow.
//  Illegal opcode (101): result=0, zero=1, err=1. Otherwise err=0.
//  States:
//   IDLE: in_ready=1, out_valid=0. On in_valid, latch all inputs.
//    - gout=100 with shamt!=0: acc<=b, cnt<=shamt, go SHIFT.
//    - All other cases (including gout=100 with shamt=0): compute result, go DONE.
//   SHIFT: in_ready=0. Each cycle acc<=acc<<1 and cnt<=cnt-1.
//    - When cnt==1 the shift completes that cycle: result<=acc<<1, go DONE.
//   DONE: out_valid=1. result/zero/err held stable until out_ready=1, then go IDLE.
//  Latency from accept edge to out_valid high:
//   - 1 cycle for non-shift ops and for shamt=0.
//   - shamt+1 cycles for SLL.
//  One operation in flight at a time. in_ready=0 in SHIFT and DONE.
//  Next accept is possible the cycle after the out_ready handshake.
//  Inputs are ignored outside IDLE. Changing a/b/gout mid-operation has no effect.
//  out_ready while not in DONE is ignored.
//  zero and err are registered together with result and change only on DONE entry.
//  Reset (any state, including mid-SHIFT): state=IDLE, in_ready=1, out_valid=0,
//   result=0, zero=0, err=0, acc=0, cnt=0. An in-flight op is dropped with no output.
//  in_ready during the reset cycle itself is 0. It is 1 from the first cycle after reset.
// TESTING
//  ADD a=0x7FFFFFFF b=1 -> result=0x80000000, zero=0, err=0, out_valid 1 cycle after accept.
//  SUB a=5 b=5 -> result=0, zero=1. SLT a=0x80000000 b=1 -> result=1.
//  SLT a=0x7FFFFFFF b=0xFFFFFFFF -> result=0 (overflow case).
//  SLL b=0x1 shamt=31 -> out_valid after 32 cycles, result=0x80000000.
//  SLL shamt=0 -> 1-cycle latency, result=b. in_ready=0 throughout the shift.
//  gout=101 -> result=0, zero=1, err=1.
//  Hold out_ready=0 for 5 cycles in DONE: result stable, in_ready=0, new in_valid ignored.
//  Release out_ready: IDLE next cycle.
//  Assert reset_n=0 mid-SHIFT (shamt=20, cycle 8): next cycle out_valid=0, result=0,
//   in_ready=1; no result is ever emitted for the aborted op.
//  Back-to-back AND/OR/NOR with out_ready tied 1 -> one result every 2 cycles.
//  Check 0xF0F0&0xFF00=0xF000, |=0xFFF0, NOR of 0,0=0xFFFFFFFF.

Source files
------------

// File: rtl/alu_exec_seq.sv
// Execution-stage ALU: single-cycle logic/arith ops and an iterative one-bit-per-cycle SLL,
// returning a registered result, zero and err flag over a valid/ready handshake.
module alu_exec_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       gout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_ILL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             zero_nxt, err_nxt;
  logic [WIDTH-1:0] op_res, diff, acc_sh;
  logic             ovf;

  // Single-cycle datapath; SLL here only covers shamt=0, where the result is b itself.
  always_comb begin
    diff   = a - b;
    ovf    = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    acc_sh = {acc[WIDTH-2:0], 1'b0};
    op_res = '0;
    case (gout)
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_ADD:  op_res = a + b;
      OP_NOR:  op_res = ~(a | b);
      OP_SLL:  op_res = b;
      OP_SUB:  op_res = diff;
      OP_SLT:  op_res = WIDTH'(diff[WIDTH-1] ^ ovf);
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    cnt_nxt    = cnt;
    result_nxt = result;
    zero_nxt   = zero;
    err_nxt    = err;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (gout == OP_SLL && shamt != '0) begin
            acc_nxt   = b;
            cnt_nxt   = shamt;
            state_nxt = SHIFT;
          end else begin
            result_nxt = op_res;
            zero_nxt   = (op_res == '0);
            err_nxt    = (gout == OP_ILL);
            state_nxt  = DONE;
          end
        end
      end
      SHIFT: begin
        acc_nxt = acc_sh;
        cnt_nxt = cnt - SHW'(1);
        if (cnt == SHW'(1)) begin
          result_nxt = acc_sh;
          zero_nxt   = (acc_sh == '0);
          err_nxt    = 1'b0;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      result    <= result_nxt;
      zero      <= zero_nxt;
      err       <= err_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule
